// File: rtl/mem_bist_master.sv
// mem_bist_master: March test engine (W0 up, R0/W1 up, R1 down) driving a single-port RAM
// req/gnt/rvalid port. Define MEM_BIST_ERR_CAPTURE_EN to keep the first failing address/data.
module mem_bist_master #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_WORDS  = 64,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 32'hA5A5_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic                    mem_en_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic [ADDR_WIDTH-1:0]   err_addr_o,
    output logic [DATA_WIDTH-1:0]   err_rdata_o
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(BE_W);
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RV, DONE} state_t;
    typedef enum logic [1:0] {PH_W0, PH_R0W1, PH_R1} phase_t;

    state_t                state_q, state_d;
    phase_t                phase_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  wr_sub_q;
    logic                  fail_q;
    logic                  op_we, start_ok, rsp, mismatch, last_op;
    logic [DATA_WIDTH-1:0] pat, op_wdata, exp_rdata;
    logic [ADDR_WIDTH-1:0] op_addr;

    // Current operation is a pure function of phase/index/sub-step registers.
    assign pat       = PATTERN ^ DATA_WIDTH'(idx_q);
    assign op_we     = (phase_q == PH_W0) || ((phase_q == PH_R0W1) && wr_sub_q);
    assign op_wdata  = (phase_q == PH_W0) ? pat : ~pat;
    assign exp_rdata = (phase_q == PH_R0W1) ? pat : ~pat;
    assign op_addr   = ADDR_WIDTH'(idx_q) << SHIFT;

    assign start_ok = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign rsp      = (state_q == WAIT_RV) && mem_rvalid_i;
    assign mismatch = rsp && !op_we && (mem_rdata_i != exp_rdata);
    assign last_op  = (phase_q == PH_R1) && (idx_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        pass_o      = 1'b0;
        mem_req_o   = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = REQ;
            end
            REQ: begin
                busy_o      = 1'b1;
                mem_req_o   = 1'b1;
                mem_en_o    = 1'b1;
                mem_be_o    = '1;
                mem_we_o    = op_we;
                mem_addr_o  = op_addr;
                mem_wdata_o = op_we ? op_wdata : '0;
                if (mem_gnt_i) state_d = WAIT_RV;
            end
            WAIT_RV: begin
                busy_o = 1'b1;
                if (mem_rvalid_i) state_d = last_op ? DONE : REQ;
            end
            DONE: begin
                done_o = 1'b1;
                pass_o = !fail_q;
                if (start_i) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencing advances only on a response, so exactly one transaction is ever outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_W0;
            idx_q    <= '0;
            wr_sub_q <= 1'b0;
            fail_q   <= 1'b0;
        end else if (start_ok) begin
            phase_q  <= PH_W0;
            idx_q    <= '0;
            wr_sub_q <= 1'b0;
            fail_q   <= 1'b0;
        end else if (rsp) begin
            if (mismatch) fail_q <= 1'b1;
            case (phase_q)
                PH_W0: begin
                    if (idx_q == LAST_IDX) begin
                        phase_q <= PH_R0W1;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                PH_R0W1: begin
                    if (!wr_sub_q) begin
                        wr_sub_q <= 1'b1;
                    end else begin
                        wr_sub_q <= 1'b0;
                        if (idx_q == LAST_IDX) phase_q <= PH_R1;
                        else                   idx_q   <= idx_q + 1'b1;
                    end
                end
                PH_R1: begin
                    if (idx_q != '0) idx_q <= idx_q - 1'b1;
                end
                default: phase_q <= PH_W0;
            endcase
        end
    end

`ifdef MEM_BIST_ERR_CAPTURE_EN
    logic [ADDR_WIDTH-1:0] err_addr_q;
    logic [DATA_WIDTH-1:0] err_rdata_q;

    // Only the first mismatch since start is kept; fail_q is still clear at that moment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr_q  <= '0;
            err_rdata_q <= '0;
        end else if (start_ok) begin
            err_addr_q  <= '0;
            err_rdata_q <= '0;
        end else if (mismatch && !fail_q) begin
            err_addr_q  <= op_addr;
            err_rdata_q <= mem_rdata_i;
        end
    end

    assign err_addr_o  = err_addr_q;
    assign err_rdata_o = err_rdata_q;
`else
    assign err_addr_o  = '0;
    assign err_rdata_o = '0;
`endif

endmodule

// File: tb/tb_mem_bist_master.sv
// tb_mem_bist_master: directed/randomized bench for mem_bist_master with a behavioural
// March sequence and RAM model, and a responder that varies grant and response latency.
module tb_mem_bist_master;
    localparam int          ADDR_WIDTH = 8;
    localparam int          DATA_WIDTH = 32;
    localparam int          NUM_WORDS  = 64;
    localparam logic [31:0] PATTERN    = 32'hA5A5_0000;
    localparam int          BE_W       = DATA_WIDTH / 8;
    localparam int          NUM_OPS    = 4 * NUM_WORDS;
    localparam int          LIMIT      = 4000;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start_i;
    logic                  busy_o, done_o, pass_o;
    logic                  mem_req_o, mem_we_o, mem_en_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [BE_W-1:0]       mem_be_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_gnt_i, mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic [ADDR_WIDTH-1:0] err_addr_o;
    logic [DATA_WIDTH-1:0] err_rdata_o;

    mem_bist_master #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS),
        .PATTERN    (PATTERN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .pass_o       (pass_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_en_o     (mem_en_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .err_addr_o   (err_addr_o),
        .err_rdata_o  (err_rdata_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_W-1:0]       be;
        logic                  en;
        logic                  stable;
    } bus_op_t;

    typedef struct {
        bit                    we;
        int                    word;
        logic [DATA_WIDTH-1:0] data;
    } march_op_t;

    int                    n_checks = 0;
    int                    n_pass   = 0;
    bus_op_t               obs_q[$];
    march_op_t             exp_q[$];
    int                    gnt_min, gnt_max, rv_min, rv_max;
    bit                    spurious, stray_rv;
    int                    extra_cycles;
    int                    stuck_word;
    logic [DATA_WIDTH-1:0] stuck_mask, stuck_bits;
    logic [DATA_WIDTH-1:0] ram [NUM_WORDS];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DATA_WIDTH-1:0] patOf(input int a);
        return PATTERN ^ DATA_WIDTH'(a);
    endfunction

    // Value a faulty RAM cell actually holds after a write.
    function automatic logic [DATA_WIDTH-1:0] stored(input int w, input logic [DATA_WIDTH-1:0] d);
        if (w == stuck_word) return (d & ~stuck_mask) | (stuck_bits & stuck_mask);
        return d;
    endfunction

    task automatic buildMarch();
        exp_q.delete();
        for (int a = 0; a < NUM_WORDS; a++) exp_q.push_back('{1'b1, a, patOf(a)});
        for (int a = 0; a < NUM_WORDS; a++) begin
            exp_q.push_back('{1'b0, a, patOf(a)});
            exp_q.push_back('{1'b1, a, ~patOf(a)});
        end
        for (int a = NUM_WORDS - 1; a >= 0; a--) exp_q.push_back('{1'b0, a, ~patOf(a)});
    endtask

    task automatic predict(output logic ep, output logic [ADDR_WIDTH-1:0] ea,
                           output logic [DATA_WIDTH-1:0] ed);
        logic [DATA_WIDTH-1:0] m [NUM_WORDS];
        ep = 1'b1;
        ea = '0;
        ed = '0;
        foreach (exp_q[k]) begin
            if (exp_q[k].we) begin
                m[exp_q[k].word] = stored(exp_q[k].word, exp_q[k].data);
            end else if (ep && (m[exp_q[k].word] !== exp_q[k].data)) begin
                ep = 1'b0;
                ea = ADDR_WIDTH'(exp_q[k].word * BE_W);
                ed = m[exp_q[k].word];
            end
        end
    endtask

    // RAM responder: grant after a chosen delay, then one response after another delay.
    initial begin : ram_responder
        int                    phase;
        int                    cnt;
        int                    gdly;
        int                    rdly;
        int                    word;
        bus_op_t               cur;
        logic [DATA_WIDTH-1:0] rsp_data;
        phase = 0; cnt = 0; gdly = 0; rdly = 0; word = 0; cur = '0; rsp_data = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            if (rst) begin
                phase = 0;
                cnt   = 0;
            end else if (phase == 0) begin
                if (mem_req_o) begin
                    if (cnt == 0) begin
                        gdly = int'($urandom_range(gnt_max, gnt_min));
                        rdly = int'($urandom_range(rv_max, rv_min));
                        cur  = '{mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_en_o, 1'b1};
                    end else if ({mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_en_o} !=
                                 {cur.we, cur.addr, cur.wdata, cur.be, cur.en}) begin
                        cur.stable = 1'b0;
                    end
                    if (cnt < gdly) begin
                        cnt++;
                        if (spurious) mem_rvalid_i = 1'b1;
                    end else begin
                        mem_gnt_i = 1'b1;
                        obs_q.push_back(cur);
                        extra_cycles += gdly;
                        word = int'(mem_addr_o) / BE_W;
                        if (word < NUM_WORDS) begin
                            if (mem_we_o) ram[word] = stored(word, mem_wdata_o);
                            rsp_data = mem_we_o ? DATA_WIDTH'($urandom) : ram[word];
                        end else begin
                            rsp_data = DATA_WIDTH'($urandom);
                        end
                        phase = 1;
                        cnt   = 0;
                    end
                end else if (stray_rv) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = DATA_WIDTH'($urandom);
                end
            end else begin
                if (cnt < rdly) begin
                    cnt++;
                end else begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = rsp_data;
                    extra_cycles += rdly;
                    phase = 0;
                    cnt   = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input int gmin, input int gmax, input int rmin, input int rmax,
                                 input bit spur);
        gnt_min = gmin; gnt_max = gmax; rv_min = rmin; rv_max = rmax; spurious = spur;
        obs_q.delete();
        extra_cycles = 0;
        buildMarch();
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        checkOutput("start busy/done", 64'({busy_o, done_o}), 64'(2'b10));
    endtask

    // Counts edges after the start edge until done; optionally pulses start while busy.
    task automatic waitDone(input int busy_at, output int lat);
        lat = 0;
        while (!done_o && lat < LIMIT) begin
            @(posedge clk);
            lat++;
            #1 start_i = (lat == busy_at);
        end
        start_i = 1'b0;
        checkOutput("done seen", 64'(done_o), 64'(1));
    endtask

    task automatic checkRun(input string tag, input int lat, input int exp_lat);
        logic                  ep;
        logic [ADDR_WIDTH-1:0] ea;
        logic [DATA_WIDTH-1:0] ed;
        bus_op_t               o, e;
        predict(ep, ea, ed);
`ifndef MEM_BIST_ERR_CAPTURE_EN
        ea = '0;
        ed = '0;
`endif
        checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, " done/busy/pass"}, 64'({done_o, busy_o, pass_o}), 64'({1'b1, 1'b0, ep}));
        checkOutput({tag, " err_addr"}, 64'(err_addr_o), 64'(ea));
        checkOutput({tag, " err_rdata"}, 64'(err_rdata_o), 64'(ed));
        checkOutput({tag, " op count"}, 64'(obs_q.size()), 64'(NUM_OPS));
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            o = obs_q[k];
            if (!o.we) o.wdata = '0;
            e = '{exp_q[k].we, ADDR_WIDTH'(exp_q[k].word * BE_W),
                  exp_q[k].we ? exp_q[k].data : '0, '1, 1'b1, 1'b1};
            checkOutput($sformatf("%s op%0d", tag, k), 64'(o), 64'(e));
        end
    endtask

    initial begin
        int lat;
        int n_wr;
        rst = 1'b1; start_i = 1'b0; stray_rv = 1'b0; spurious = 1'b0;
        gnt_min = 0; gnt_max = 0; rv_min = 0; rv_max = 0; extra_cycles = 0;
        stuck_word = -1; stuck_mask = '0; stuck_bits = '0;
        lat = 0; n_wr = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ctl", 64'({busy_o, done_o, pass_o, mem_req_o, mem_we_o, mem_en_o,
                                      mem_be_o, mem_addr_o, err_addr_o}), 64'(0));
        checkOutput("reset data", {mem_wdata_o, err_rdata_o}, 64'(0));
        #2 rst = 1'b0;
        @(posedge clk);
        #1 checkOutput("idle after reset", 64'({busy_o, done_o, pass_o, mem_req_o}), 64'(0));

        // Ideal RAM, no fault
        applyStimulus(0, 0, 0, 0, 1'b0);
        waitDone(0, lat);
        checkRun("zero-wait", lat, 8 * NUM_WORDS);
        checkOutput("first write data", 64'(obs_q[0].wdata), 64'h0000_0000_A5A5_0000);
        foreach (obs_q[k]) if (obs_q[k].we) n_wr++;
        checkOutput("write count", 64'(n_wr), 64'(128));
        repeat (5) @(posedge clk);
        #1 checkOutput("done held", 64'({done_o, pass_o, busy_o}), 64'(3'b110));

        // Word 5 bit 0 stuck at 1
        stuck_word = 5; stuck_mask = 32'h1; stuck_bits = 32'h1;
        applyStimulus(0, 0, 0, 0, 1'b0);
        waitDone(0, lat);
        checkRun("stuck5", lat, 8 * NUM_WORDS);
        checkOutput("stuck5 pass", 64'(pass_o), 64'(0));
`ifdef MEM_BIST_ERR_CAPTURE_EN
        checkOutput("stuck5 err_addr const", 64'(err_addr_o), 64'h14);
        checkOutput("stuck5 err_rdata const", 64'(err_rdata_o), 64'h5A5A_FFFB);
`else
        checkOutput("stuck5 err_addr const", 64'(err_addr_o), 64'h0);
        checkOutput("stuck5 err_rdata const", 64'(err_rdata_o), 64'h0);
`endif

        // Grant held off 3 cycles, spurious zero-data rvalid while waiting for grant
        stuck_word = -1;
        applyStimulus(3, 3, 0, 0, 1'b1);
        waitDone(0, lat);
        checkRun("gnt3", lat, 8 * NUM_WORDS + 3 * NUM_OPS);

        // Random latencies, random stuck bit, start pulsed while busy
        for (int r = 0; r < 3; r++) begin
            stuck_word = int'($urandom_range(NUM_WORDS - 1, 0));
            stuck_mask = 32'h1 << $urandom_range(31, 0);
            stuck_bits = DATA_WIDTH'($urandom);
            applyStimulus(0, 3, 0, 2, (r == 1));
            waitDone(20 + r * 150, lat);
            checkRun($sformatf("rand%0d", r), lat, 8 * NUM_WORDS + extra_cycles);
        end

        // Reset during the R0W1 phase, stray responses in idle, then a clean restart
        stuck_word = -1;
        applyStimulus(0, 2, 0, 1, 1'b0);
        for (int c = 0; c < LIMIT && obs_q.size() <= NUM_WORDS + 10; c++) @(posedge clk);
        checkOutput("reached R0W1", 64'(obs_q.size() > NUM_WORDS + 10), 64'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("mid reset ctl", 64'({busy_o, done_o, pass_o, mem_req_o, mem_we_o, mem_en_o,
                                             mem_be_o, mem_addr_o, err_addr_o}), 64'(0));
        checkOutput("mid reset data", {mem_wdata_o, err_rdata_o}, 64'(0));
        @(posedge clk);
        #1 checkOutput("req low in reset", 64'(mem_req_o), 64'(0));
        @(negedge clk);
        #2 rst = 1'b0;
        stray_rv = 1'b1;
        repeat (4) @(posedge clk);
        #1 checkOutput("idle ignores rvalid", 64'({busy_o, done_o, pass_o, mem_req_o}), 64'(0));
        stray_rv = 1'b0;
        applyStimulus(0, 2, 0, 1, 1'b0);
        waitDone(0, lat);
        checkRun("after reset", lat, 8 * NUM_WORDS + extra_cycles);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
